pcm_sample_pacer: RTL and testbench
===================================

// Module: pcm_sample_pacer
// PURPOSE
// - Audio playback stage between the 16-bit sample FIFO (fifo_256w) and the delta-sigma DAC (dac16).
// - Generates the sample-rate tick, pops one FIFO word per tick and presents it as an unsigned PCM word.
// - Handles prefill, underrun (click-free ramp to midscale) and stop/fade; exposes status for the UART register map.
// PARAMETERS
// - TICK_DIV    2000    clk cycles per sample period (96 MHz / 48 kHz); legal range 4..65535
// - RD_LAT      1       cycles from fifo_rd_en to valid fifo_dout (1 = standard FIFO, 0 = FWFT); legal 0..2
// - SIGNED_IN   1       1: FIFO words are two's complement, MSB inverted to offset-binary; 0: passed through
// - RAMP_STEP   16'h0100 per-tick step toward 16'h8000 while starved/fading
// PORTS
// - clk           in   1   system clock (clk96m)
// - rst           in   1   synchronous, active-high reset
// - en            in   1   playback enable (level)
// - fifo_empty    in   1   FIFO empty flag
// - fifo_prog     in   1   FIFO programmable-full flag (prefill threshold)
// - fifo_dout     in   16  FIFO read data
// - fifo_rd_en    out  1   FIFO pop, single-cycle pulse
// - pcm           out  16  offset-binary sample to dac16 (16'h8000 = silence)
// - sample_tick   out  1   one-cycle pulse at start of each sample period
// - state         out  2   00 IDLE, 01 PLAY, 10 STARVED, 11 FADE
// - underrun_cnt  out  16  number of starved ticks, saturating
// BEHAVIOUR
// - Reset: tick counter=0, fifo_rd_en=0, sample_tick=0, pcm=16'h8000, state=IDLE, underrun_cnt=0.
// - Tick counter: 0..TICK_DIV-1, wraps; sample_tick=1 in the cycle counter==TICK_DIV-1 (period exactly TICK_DIV). Counter runs in all states.
// - Pop rule: fifo_rd_en asserted in the sample_tick cycle only if fifo_empty=0 and state is PLAY or STARVED. Never more than one pop per tick.
// - Capture: fifo_dout registered RD_LAT cycles after fifo_rd_en (RD_LAT=0: same cycle); pcm updates the following cycle; pcm = SIGNED_IN ? {~d[15],d[14:0]} : d.
// - pcm only changes on a capture or a ramp step; otherwise held constant.
// - IDLE: pcm=16'h8000; en=1 and fifo_prog=1 -> PLAY (prefill; first pop on next tick).
// - PLAY: tick with fifo_empty=0 -> pop; tick with fifo_empty=1 -> underrun_cnt+1 (saturate at 16'hFFFF), -> STARVED, pcm held this tick.
// - STARVED: tick with fifo_empty=0 -> pop, -> PLAY; tick with fifo_empty=1 -> underrun_cnt+1, pcm steps RAMP_STEP toward 16'h8000, clamped (no overshoot).
// - en=0 in PLAY/STARVED -> FADE next cycle; pending capture (pop already issued) still completes.
// - FADE: no pops; each tick pcm steps toward 16'h8000; pcm==16'h8000 -> IDLE. en=1 in FADE: stay until IDLE (no resume mid-fade).
// - en=0 in IDLE: stay. underrun_cnt cleared only by rst.
// - Ramp arithmetic: 17-bit compare/subtract; pcm>8000: pcm=max(pcm-STEP,8000); pcm<8000: pcm=min(pcm+STEP,8000).
// - Reset mid-operation: all outputs to reset values the next cycle, in-flight capture discarded.
// TESTING
// - Reset then en=1, fifo_prog=0 for 10 ticks -> state=IDLE, no fifo_rd_en, pcm=16'h8000.
// - FIFO preloaded 0x0000,0x7FFF,0x8000 (SIGNED_IN=1), fifo_prog=1, en=1 -> pops exactly TICK_DIV cycles apart; pcm=8000,FFFF,0000 at RD_LAT+1 after each pop.
// - Drain FIFO while playing last pcm=16'h8400 -> STARVED, underrun_cnt 1,2,3.. per tick, pcm 8400,8300,...,8000 then constant; refill -> PLAY on next tick with new sample.
// - Drop en with pcm=16'h7F80 -> FADE, no pops, pcm 7F80->8000 clamped on first tick, then IDLE.
// - Force 70000 starved ticks (small TICK_DIV=4) -> underrun_cnt saturates at 16'hFFFF.
// - Assert rst one cycle between pop and capture (RD_LAT=1) -> pcm=16'h8000, state=IDLE, no stale capture afterwards.

Source files
------------

// File: rtl/pcm_sample_pacer.sv
// Sample-rate pacer between the 16-bit sample FIFO and the DAC: pops one word per
// sample tick, converts to offset-binary and ramps to midscale on underrun or stop.
module pcm_sample_pacer #(
  parameter int unsigned TICK_DIV  = 2000,
  parameter int unsigned RD_LAT    = 1,
  parameter bit          SIGNED_IN = 1'b1,
  parameter logic [15:0] RAMP_STEP = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic        fifo_prog,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [15:0] pcm,
  output logic        sample_tick,
  output logic [1:0]  state,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 16;

  localparam logic [DW-1:0]    MID       = 16'h8000;
  localparam logic [DW-1:0]    CNT_SAT   = 16'hFFFF;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_DIV - 2);
  // Pipeline stages that still hold a pop whose data has not been captured yet.
  localparam logic [1:0]       PEND_MASK = 2'((3'd1 << RD_LAT) - 3'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAY    = 2'b01,
    STARVED = 2'b10,
    FADE    = 2'b11
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       rd_pipe;
  logic             cap_now;
  logic             cap_pend;
  logic             playing;
  logic             starve_tick;
  logic             ramp_tick;
  logic [DW-1:0]    pcm_in;

  // One step of RAMP_STEP toward midscale, clamped so it never crosses 16'h8000.
  function automatic logic [DW-1:0] ramp_to_mid(input logic [DW-1:0] v);
    logic [DW:0] t;
    t = {1'b0, v};
    ramp_to_mid = v;
    if (v > MID) begin
      t = {1'b0, v} - {1'b0, RAMP_STEP};
      ramp_to_mid = (t[DW] || (t < {1'b0, MID})) ? MID : t[DW-1:0];
    end else if (v < MID) begin
      t = {1'b0, v} + {1'b0, RAMP_STEP};
      ramp_to_mid = (t > {1'b0, MID}) ? MID : t[DW-1:0];
    end
  endfunction

  assign state       = st;
  assign playing     = (st == PLAY) || (st == STARVED);
  assign starve_tick = sample_tick && fifo_empty && playing;
  assign ramp_tick   = sample_tick && (((st == STARVED) && fifo_empty) || (st == FADE));
  assign cap_pend    = |(rd_pipe & PEND_MASK);
  assign pcm_in      = SIGNED_IN ? {~fifo_dout[DW-1], fifo_dout[DW-2:0]} : fifo_dout;

  // Pop decode uses the live empty flag so a word written during the tick cycle is not missed.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && sample_tick && !fifo_empty && playing) begin
      fifo_rd_en = 1'b1;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_cap_fwft
      assign cap_now = fifo_rd_en;
    end else begin : g_cap_reg
      assign cap_now = rd_pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      sample_tick  <= 1'b0;
      rd_pipe      <= '0;
      pcm          <= MID;
      st           <= IDLE;
      underrun_cnt <= '0;
    end else begin
      tick_cnt    <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_W'(1);
      sample_tick <= (tick_cnt == TICK_PRE);
      rd_pipe     <= {rd_pipe[0], fifo_rd_en};

      if (cap_now) begin
        pcm <= pcm_in;
      end else if (ramp_tick) begin
        pcm <= ramp_to_mid(pcm);
      end

      if (starve_tick && (underrun_cnt != CNT_SAT)) begin
        underrun_cnt <= underrun_cnt + DW'(1);
      end

      case (st)
        IDLE: begin
          if (en && fifo_prog) st <= PLAY;
        end
        PLAY: begin
          if (!en) st <= FADE;
          else if (sample_tick && fifo_empty) st <= STARVED;
        end
        STARVED: begin
          if (!en) st <= FADE;
          else if (sample_tick && !fifo_empty) st <= PLAY;
        end
        FADE: begin
          // A pop issued just before the stop must land before we call it silent.
          if ((pcm == MID) && !cap_pend) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_sample_pacer.sv
// Directed bench for pcm_sample_pacer: tick-by-tick vector table plus hand-written
// sequences for output latency, reset between pop and capture, and counter saturation.
module tb_pcm_sample_pacer;

  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned RD_LAT   = 1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_PLAY    = 2'b01;
  localparam logic [1:0] S_STARVED = 2'b10;
  localparam logic [1:0] S_FADE    = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_prog = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = 16'h0000;
  logic        fifo_rd_en;
  logic [15:0] pcm;
  logic        sample_tick;
  logic [1:0]  state;
  logic [15:0] underrun_cnt;

  pcm_sample_pacer #(
    .TICK_DIV (TICK_DIV),
    .RD_LAT   (RD_LAT),
    .SIGNED_IN(1'b1),
    .RAMP_STEP(16'h0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_prog   (fifo_prog),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .pcm         (pcm),
    .sample_tick (sample_tick),
    .state       (state),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // Standard (one-cycle read latency) FIFO model
  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  int last_pop = -1;
  int prev_pop = -1;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      prev_pop <= last_pop;
      last_pop <= cyc;
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int pops  = 0;

  typedef struct {
    bit          en;
    bit          prog;
    int          npush;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    int          reps;
    logic [1:0]  st;
    logic [15:0] pcm;
    logic [15:0] ucnt;
    int          pops;
    bit          gap;
  } vec_t;

  vec_t tbl [$];
  vec_t v;

  function automatic vec_t mk(input bit e, input bit p, input int np,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input int reps, input logic [1:0] s, input logic [15:0] pc,
                              input logic [15:0] uc, input int npop, input bit g);
    vec_t r;
    r.en = e; r.prog = p; r.npush = np; r.w0 = a; r.w1 = b; r.w2 = c;
    r.reps = reps; r.st = s; r.pcm = pc; r.ucnt = uc; r.pops = npop; r.gap = g;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Advance to the next sample tick, then two more cycles so any capture has landed.
  task automatic wait_tick();
    bit hit;
    hit  = 1'b0;
    pops = 0;
    for (int i = 0; i < 2 * TICK_DIV && !hit; i++) begin
      @(negedge clk);
      if (fifo_rd_en) pops++;
      hit = sample_tick;
    end
    if (!hit) begin
      n_vec++;
      n_bad++;
      $display("FAIL tick_timeout: got no sample_tick expected one within %0d cycles", 2 * TICK_DIV);
    end
    repeat (2) begin
      @(negedge clk);
      if (fifo_rd_en) pops++;
    end
  endtask

  task automatic wait_pop(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV && !hit; i++) begin
      @(negedge clk);
      hit = fifo_rd_en;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  initial begin
    bit stale;

    // en, prog, npush, w0, w1, w2, reps, state, pcm, underrun, pops, gap
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 10, S_IDLE,    16'h8000, 16'd0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 16'h0000, 16'h7FFF, 16'h8000, 1,  S_PLAY,    16'h8000, 16'd0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_PLAY,    16'hFFFF, 16'd0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h0000, 16'd0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0400, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h8400, 16'd0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8400, 16'd1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8300, 16'd2, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8200, 16'd3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8100, 16'd4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8000, 16'd5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8000, 16'd6, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h1234, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h9234, 16'd6, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFF80, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h7F80, 16'd6, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'h2222, 16'h0000, 16'h0000, 1,  S_IDLE,    16'h8000, 16'd6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_IDLE,    16'h8000, 16'd6, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_PLAY,    16'hA222, 16'd6, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'h0250, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h8250, 16'd6, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_FADE,    16'h8150, 16'd6, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'h0001, 16'h0000, 16'h0000, 1,  S_FADE,    16'h8050, 16'd6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_IDLE,    16'h8000, 16'd6, 0, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_PLAY,    16'h8001, 16'd6, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8001, 16'd7, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_STARVED, 16'h8000, 16'd8, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1,  S_IDLE,    16'h8000, 16'd8, 0, 0));

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_pcm", 32'(pcm), 32'h8000);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;

    // Tick position and period
    repeat (7) @(negedge clk);
    check("first_tick", 32'(sample_tick), 32'd1);
    @(negedge clk);
    check("tick_width", 32'(sample_tick), 32'd0);
    repeat (7) @(negedge clk);
    check("tick_period", 32'(sample_tick), 32'd1);

    foreach (tbl[i]) begin
      v = tbl[i];
      en = v.en;
      fifo_prog = v.prog;
      if (v.npush > 0) push(v.w0);
      if (v.npush > 1) push(v.w1);
      if (v.npush > 2) push(v.w2);
      for (int r = 0; r < v.reps; r++) begin
        wait_tick();
        check($sformatf("v%0d.%0d state", i, r), 32'(state), 32'(v.st));
        check($sformatf("v%0d.%0d pcm", i, r), 32'(pcm), 32'(v.pcm));
        check($sformatf("v%0d.%0d underrun", i, r), 32'(underrun_cnt), 32'(v.ucnt));
        check($sformatf("v%0d.%0d pops", i, r), 32'(pops), 32'(v.pops));
        if (v.gap) check($sformatf("v%0d pop_gap", i), 32'(last_pop - prev_pop), 32'(TICK_DIV));
      end
    end

    // Capture latency: pcm changes RD_LAT+1 cycles after the pop
    push(16'h1111);
    fifo_prog = 1'b1;
    en = 1'b1;
    wait_pop("lat_pop_seen");
    check("lat_pop_on_tick", 32'(sample_tick), 32'd1);
    check("lat_pcm_at_pop", 32'(pcm), 32'h8000);
    @(negedge clk);
    check("lat_pcm_plus1", 32'(pcm), 32'h8000);
    check("lat_state", 32'(state), 32'(S_PLAY));
    @(negedge clk);
    check("lat_pcm_plus2", 32'(pcm), 32'h9111);

    // Reset in the cycle between pop and capture
    fifo_prog = 1'b0;
    push(16'h0300);
    wait_pop("mid_pop_seen");
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pcm", 32'(pcm), 32'h8000);
    check("mid_rst_state", 32'(state), 32'(S_IDLE));
    check("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
    check("mid_rst_tick", 32'(sample_tick), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      @(negedge clk);
      if (pcm != 16'h8000 || fifo_rd_en) stale = 1'b1;
    end
    check("mid_rst_no_stale", 32'(stale), 32'd0);

    // Underrun counter saturation (counter preset near the top)
    en = 1'b1;
    fifo_prog = 1'b1;
    wait_tick();
    check("sat_state", 32'(state), 32'(S_STARVED));
    check("sat_first", 32'(underrun_cnt), 32'd1);
    force dut.underrun_cnt = 16'hFFFF;
    wait_tick();
    release dut.underrun_cnt;
    check("sat_hold0", 32'(underrun_cnt), 32'hFFFF);
    wait_tick();
    check("sat_hold1", 32'(underrun_cnt), 32'hFFFF);
    wait_tick();
    check("sat_hold2", 32'(underrun_cnt), 32'hFFFF);
    check("sat_pcm", 32'(pcm), 32'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
